// File: rtl/msrv_32_pkg.sv
// -----------------------------------------------------------------------------
// msrv_32_pkg
// Shared definitions for the MSRV integer register file slice:
//   XLEN_DEF / NREG_DEF : default register width and register count
//   ZERO_REG            : index of the hard-wired zero register
//   calc_aw()           : address width for a given register count
// -----------------------------------------------------------------------------
package msrv_32_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int ZERO_REG = 0;

  // NREG is a power of two in 2..64, so this is exact; 1 is kept as a floor.
  function automatic int calc_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/msrv_32_mp_integer_file_if.sv
// -----------------------------------------------------------------------------
// msrv_32_mp_integer_file_if
// Bus bundle between the issue/writeback logic and the integer register file.
//   master : issue/writeback side (drives addresses, writes, issue, flush)
//   slave  : register file (returns read data, pending bits, pending count)
// Signals:
//   rs_addr_in   NRP*AW    read addresses, port p at [p*AW +: AW]
//   rs_data_out  NRP*XLEN  read data per port
//   rs_pend_out  NRP       pending flag of the addressed register
//   wr_en_in     NWP       write enables
//   wr_addr_in   NWP*AW    write addresses
//   wr_data_in   NWP*XLEN  write data
//   iss_en_in    1         destination-carrying instruction issues
//   iss_addr_in  AW        destination of the issuing instruction
//   flush_in     1         clear all pending bits
//   pend_cnt_out AW+1      number of pending registers (registered)
// -----------------------------------------------------------------------------
interface msrv_32_mp_integer_file_if
  import msrv_32_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRP  = 2,
  parameter int NWP  = 2
);
  localparam int AW = calc_aw(NREG);

  logic [NRP*AW-1:0]   rs_addr_in;
  logic [NRP*XLEN-1:0] rs_data_out;
  logic [NRP-1:0]      rs_pend_out;
  logic [NWP-1:0]      wr_en_in;
  logic [NWP*AW-1:0]   wr_addr_in;
  logic [NWP*XLEN-1:0] wr_data_in;
  logic                iss_en_in;
  logic [AW-1:0]       iss_addr_in;
  logic                flush_in;
  logic [AW:0]         pend_cnt_out;

  modport master (
    output rs_addr_in, wr_en_in, wr_addr_in, wr_data_in,
           iss_en_in, iss_addr_in, flush_in,
    input  rs_data_out, rs_pend_out, pend_cnt_out
  );

  modport slave (
    input  rs_addr_in, wr_en_in, wr_addr_in, wr_data_in,
           iss_en_in, iss_addr_in, flush_in,
    output rs_data_out, rs_pend_out, pend_cnt_out
  );

endinterface

// File: rtl/msrv_32_scoreboard.sv
// -----------------------------------------------------------------------------
// msrv_32_scoreboard
// Per-register pending-write tracker with an incrementally maintained count.
// Ports:
//   ms_risc32_mp_clk_in  clock, rising edge
//   ms_risc32_mp_rst_in  asynchronous active-high reset
//   iss_en_in/iss_addr_in  set request (new producer issued)
//   flush_in               clear everything
//   wr_en_in/wr_addr_in    clear requests (writebacks)
//   pend_out               stored pending vector, bit 0 always 0
//   pend_cnt_out           population count of pend_out
// -----------------------------------------------------------------------------
module msrv_32_scoreboard
  import msrv_32_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NWP  = 2,
  parameter int AW   = calc_aw(NREG)
) (
  input  logic              ms_risc32_mp_clk_in,
  input  logic              ms_risc32_mp_rst_in,
  input  logic              iss_en_in,
  input  logic [AW-1:0]     iss_addr_in,
  input  logic              flush_in,
  input  logic [NWP-1:0]    wr_en_in,
  input  logic [NWP*AW-1:0] wr_addr_in,
  output logic [NREG-1:0]   pend_out,
  output logic [AW:0]       pend_cnt_out
);

  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] ZERO_A  = AW'(ZERO_REG);

  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW-1:0]   clr_addr;

  // Clears are applied before the set so that an issue to the address being
  // written back leaves it pending: the clear decrements, the set re-increments.
  // Only clears of bits that are still set count, so two ports retiring the
  // same register decrement once.
  always_comb begin
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    clr_addr = '0;
    if (flush_in) begin
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      for (int w = 0; w < NWP; w++) begin
        clr_addr = wr_addr_in[w*AW +: AW];
        if (wr_en_in[w] && clr_addr != ZERO_A && pend_d[clr_addr]) begin
          pend_d[clr_addr] = 1'b0;
          cnt_d            = cnt_d - CNT_ONE;
        end
      end
      if (iss_en_in && iss_addr_in != ZERO_A && !pend_d[iss_addr_in]) begin
        pend_d[iss_addr_in] = 1'b1;
        cnt_d               = cnt_d + CNT_ONE;
      end
    end
    pend_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
    if (ms_risc32_mp_rst_in) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_out     = pend_q;
  assign pend_cnt_out = cnt_q;

endmodule

// File: rtl/msrv_32_mp_integer_file.sv
// -----------------------------------------------------------------------------
// msrv_32_mp_integer_file
// Multi-port integer register file with pending-write scoreboard.
// NRP combinational read ports, NWP write ports (higher index wins), x0 = 0.
// Ports:
//   ms_risc32_mp_clk_in  clock, rising edge
//   ms_risc32_mp_rst_in  asynchronous active-high reset
//   bus                  msrv_32_mp_integer_file_if.slave (reads, writes,
//                        issue, flush, pending flags and count)
// Build option:
//   MSRV_MP_INTEGER_FILE_FWD_EN  same-cycle write-to-read forwarding; a
//                                forwarded read also reports not pending.
// -----------------------------------------------------------------------------
module msrv_32_mp_integer_file
  import msrv_32_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRP  = 2,
  parameter int NWP  = 2
) (
  input logic                       ms_risc32_mp_clk_in,
  input logic                       ms_risc32_mp_rst_in,
  msrv_32_mp_integer_file_if.slave  bus
);

  localparam int            AW     = calc_aw(NREG);
  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [NREG-1:0]     pend;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_pend;
  logic [AW-1:0]       ra;
  logic [AW-1:0]       wa;

  // Ports are visited in ascending order, so the last (highest-index)
  // assignment to a shared address is the one that lands.
  always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
    if (ms_risc32_mp_rst_in) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int w = 0; w < NWP; w++) begin
        if (bus.wr_en_in[w] && bus.wr_addr_in[w*AW +: AW] != ZERO_A)
          regs_q[bus.wr_addr_in[w*AW +: AW]] <= bus.wr_data_in[w*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    ra      = '0;
    wa      = '0;
    for (int p = 0; p < NRP; p++) begin
      ra = bus.rs_addr_in[p*AW +: AW];
      if (ra != ZERO_A) rd_data[p*XLEN +: XLEN] = regs_q[ra];
      rd_pend[p] = pend[ra];
`ifdef MSRV_MP_INTEGER_FILE_FWD_EN
      for (int w = 0; w < NWP; w++) begin
        wa = bus.wr_addr_in[w*AW +: AW];
        if (bus.wr_en_in[w] && wa != ZERO_A && wa == ra) begin
          rd_data[p*XLEN +: XLEN] = bus.wr_data_in[w*XLEN +: XLEN];
          rd_pend[p]              = 1'b0;
        end
      end
`endif
    end
  end

  assign bus.rs_data_out = rd_data;
  assign bus.rs_pend_out = rd_pend;

  msrv_32_scoreboard #(
    .NREG (NREG),
    .NWP  (NWP),
    .AW   (AW)
  ) u_scoreboard (
    .ms_risc32_mp_clk_in (ms_risc32_mp_clk_in),
    .ms_risc32_mp_rst_in (ms_risc32_mp_rst_in),
    .iss_en_in           (bus.iss_en_in),
    .iss_addr_in         (bus.iss_addr_in),
    .flush_in            (bus.flush_in),
    .wr_en_in            (bus.wr_en_in),
    .wr_addr_in          (bus.wr_addr_in),
    .pend_out            (pend),
    .pend_cnt_out        (bus.pend_cnt_out)
  );

endmodule

// File: tb/tb_msrv_32_mp_integer_file.sv
module tb_msrv_32_mp_integer_file;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msrv_32_mp_integer_file_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) bus ();

  msrv_32_mp_integer_file #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) dut (
    .ms_risc32_mp_clk_in (clk),
    .ms_risc32_mp_rst_in (rst),
    .bus                 (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en_in    = '0;
    bus.wr_addr_in  = '0;
    bus.wr_data_in  = '0;
    bus.iss_en_in   = 1'b0;
    bus.iss_addr_in = '0;
    bus.flush_in    = 1'b0;
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] data);
    bus.wr_en_in[port]             = 1'b1;
    bus.wr_addr_in[port*AW +: AW]  = AW'(addr);
    bus.wr_data_in[port*XLEN +: XLEN] = data;
  endtask

  task automatic iss(input int addr);
    bus.iss_en_in   = 1'b1;
    bus.iss_addr_in = AW'(addr);
  endtask

  task automatic rd(input int a0, input int a1);
    bus.rs_addr_in[0 +: AW]  = AW'(a0);
    bus.rs_addr_in[AW +: AW] = AW'(a1);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.pend_cnt_out !== 6'd0) $display("FAIL reset_cnt got %0d exp 0", bus.pend_cnt_out);
    else n_pass++;
    for (int i = 0; i < NREG; i++) begin
      rd(i, NREG - 1 - i);
      n_total++;
      if (bus.rs_data_out !== 64'h0)
        $display("FAIL reset_data addr %0d got %h exp 0", i, bus.rs_data_out);
      else n_pass++;
      n_total++;
      if (bus.rs_pend_out !== 2'b00)
        $display("FAIL reset_pend addr %0d got %b exp 00", i, bus.rs_pend_out);
      else n_pass++;
    end
  endtask

  task automatic test_write_priority();
    wr(0, 5, 32'hDEADBEEF);
    wr(1, 5, 32'h12345678);
    step();
    idle();
    rd(5, 5);
    n_total++;
    if (bus.rs_data_out !== {32'h12345678, 32'h12345678})
      $display("FAIL wr_priority got %h exp 12345678 on both ports", bus.rs_data_out);
    else n_pass++;
  endtask

  task automatic test_x0();
    wr(0, 0, 32'hFFFFFFFF);
    wr(1, 0, 32'hFFFFFFFF);
    rd(0, 0);
    n_total++;
    if (bus.rs_data_out !== 64'h0) $display("FAIL x0_same_cycle got %h exp 0", bus.rs_data_out);
    else n_pass++;
    step();
    idle();
    rd(0, 0);
    n_total++;
    if (bus.rs_data_out !== 64'h0) $display("FAIL x0_after got %h exp 0", bus.rs_data_out);
    else n_pass++;
  endtask

  task automatic test_issue_wb();
    iss(7);
    step();
    idle();
    rd(7, 0);
    n_total++;
    if (bus.rs_pend_out[0] !== 1'b1) $display("FAIL iss_pend got %b exp 1", bus.rs_pend_out[0]);
    else n_pass++;
    n_total++;
    if (bus.pend_cnt_out !== 6'd1) $display("FAIL iss_cnt got %0d exp 1", bus.pend_cnt_out);
    else n_pass++;
    wr(0, 7, 32'h55);
    step();
    idle();
    rd(7, 0);
    n_total++;
    if (bus.rs_pend_out[0] !== 1'b0) $display("FAIL wb_pend got %b exp 0", bus.rs_pend_out[0]);
    else n_pass++;
    n_total++;
    if (bus.pend_cnt_out !== 6'd0) $display("FAIL wb_cnt got %0d exp 0", bus.pend_cnt_out);
    else n_pass++;
    n_total++;
    if (bus.rs_data_out[31:0] !== 32'h55) $display("FAIL wb_data got %h exp 55", bus.rs_data_out[31:0]);
    else n_pass++;
  endtask

  task automatic test_issue_wb_same();
    iss(9);
    step();
    idle();
    iss(9);
    wr(1, 9, 32'h99);
    step();
    idle();
    rd(9, 9);
    n_total++;
    if (bus.rs_pend_out !== 2'b11) $display("FAIL same_pend got %b exp 11", bus.rs_pend_out);
    else n_pass++;
    n_total++;
    if (bus.pend_cnt_out !== 6'd1) $display("FAIL same_cnt got %0d exp 1", bus.pend_cnt_out);
    else n_pass++;
    n_total++;
    if (bus.rs_data_out[63:32] !== 32'h99) $display("FAIL same_data got %h exp 99", bus.rs_data_out[63:32]);
    else n_pass++;
    wr(0, 9, 32'h99);
    step();
    idle();
    n_total++;
    if (bus.pend_cnt_out !== 6'd0) $display("FAIL same_retire_cnt got %0d exp 0", bus.pend_cnt_out);
    else n_pass++;
  endtask

  task automatic test_flush();
    iss(3); step();
    iss(4); step();
    iss(6); step();
    idle();
    n_total++;
    if (bus.pend_cnt_out !== 6'd3) $display("FAIL flush_pre_cnt got %0d exp 3", bus.pend_cnt_out);
    else n_pass++;
    iss(4);
    step();
    idle();
    rd(3, 6);
    n_total++;
    if (bus.pend_cnt_out !== 6'd3) $display("FAIL reissue_cnt got %0d exp 3", bus.pend_cnt_out);
    else n_pass++;
    n_total++;
    if (bus.rs_pend_out !== 2'b11) $display("FAIL flush_pre_pend got %b exp 11", bus.rs_pend_out);
    else n_pass++;
    bus.flush_in = 1'b1;
    iss(10);
    wr(0, 8, 32'h88);
    step();
    idle();
    rd(10, 8);
    n_total++;
    if (bus.pend_cnt_out !== 6'd0) $display("FAIL flush_cnt got %0d exp 0", bus.pend_cnt_out);
    else n_pass++;
    n_total++;
    if (bus.rs_pend_out !== 2'b00) $display("FAIL flush_pend got %b exp 00", bus.rs_pend_out);
    else n_pass++;
    n_total++;
    if (bus.rs_data_out[63:32] !== 32'h88) $display("FAIL flush_write got %h exp 88", bus.rs_data_out[63:32]);
    else n_pass++;
  endtask

  task automatic test_dual_clear();
    iss(20);
    step();
    idle();
    wr(0, 20, 32'h1);
    wr(1, 20, 32'h2);
    step();
    idle();
    rd(20, 0);
    n_total++;
    if (bus.pend_cnt_out !== 6'd0) $display("FAIL dual_clear_cnt got %0d exp 0", bus.pend_cnt_out);
    else n_pass++;
    n_total++;
    if (bus.rs_data_out[31:0] !== 32'h2) $display("FAIL dual_clear_data got %h exp 2", bus.rs_data_out[31:0]);
    else n_pass++;
  endtask

  task automatic test_forward();
    wr(0, 10, 32'h11);
    step();
    idle();
    iss(10);
    step();
    idle();
    wr(0, 10, 32'h00005A5A);
    wr(1, 10, 32'hA5A5A5A5);
    rd(10, 0);
`ifdef MSRV_MP_INTEGER_FILE_FWD_EN
    n_total++;
    if (bus.rs_data_out[31:0] !== 32'hA5A5A5A5)
      $display("FAIL fwd_data got %h exp a5a5a5a5", bus.rs_data_out[31:0]);
    else n_pass++;
    n_total++;
    if (bus.rs_pend_out[0] !== 1'b0) $display("FAIL fwd_pend got %b exp 0", bus.rs_pend_out[0]);
    else n_pass++;
`else
    n_total++;
    if (bus.rs_data_out[31:0] !== 32'h11)
      $display("FAIL nofwd_data got %h exp 11", bus.rs_data_out[31:0]);
    else n_pass++;
    n_total++;
    if (bus.rs_pend_out[0] !== 1'b1) $display("FAIL nofwd_pend got %b exp 1", bus.rs_pend_out[0]);
    else n_pass++;
`endif
    step();
    idle();
    rd(10, 0);
    n_total++;
    if (bus.rs_data_out[31:0] !== 32'hA5A5A5A5)
      $display("FAIL fwd_next_data got %h exp a5a5a5a5", bus.rs_data_out[31:0]);
    else n_pass++;
    n_total++;
    if (bus.rs_pend_out[0] !== 1'b0) $display("FAIL fwd_next_pend got %b exp 0", bus.rs_pend_out[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    wr(0, 2, 32'h77);
    step();
    idle();
    for (int a = 11; a <= 14; a++) begin
      iss(a);
      step();
    end
    idle();
    rd(2, 12);
    n_total++;
    if (bus.pend_cnt_out !== 6'd4) $display("FAIL mid_pre_cnt got %0d exp 4", bus.pend_cnt_out);
    else n_pass++;
    n_total++;
    if (bus.rs_data_out[31:0] !== 32'h77) $display("FAIL mid_pre_data got %h exp 77", bus.rs_data_out[31:0]);
    else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.rs_data_out[31:0] !== 32'h0) $display("FAIL mid_rst_data got %h exp 0", bus.rs_data_out[31:0]);
    else n_pass++;
    n_total++;
    if (bus.pend_cnt_out !== 6'd0) $display("FAIL mid_rst_cnt got %0d exp 0", bus.pend_cnt_out);
    else n_pass++;
    n_total++;
    if (bus.rs_pend_out !== 2'b00) $display("FAIL mid_rst_pend got %b exp 00", bus.rs_pend_out);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr(0, 2, 32'h33);
    iss(11);
    step();
    idle();
    rd(2, 11);
    n_total++;
    if (bus.rs_data_out[31:0] !== 32'h33) $display("FAIL post_rst_data got %h exp 33", bus.rs_data_out[31:0]);
    else n_pass++;
    n_total++;
    if (bus.pend_cnt_out !== 6'd1 || bus.rs_pend_out[1] !== 1'b1)
      $display("FAIL post_rst_pend got cnt %0d pend %b exp cnt 1 pend 1", bus.pend_cnt_out, bus.rs_pend_out[1]);
    else n_pass++;
  endtask

  initial begin
    idle();
    bus.rs_addr_in = '0;
    test_reset();
    test_write_priority();
    test_x0();
    test_issue_wb();
    test_issue_wb_same();
    test_flush();
    test_dual_clear();
    test_forward();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
